// File: rtl/matrix_pkg.sv
// Shared constants and scan state encoding for the 8x8 LED matrix scan driver.
package matrix_pkg;

    localparam int ROWS    = 8;
    localparam int COLS    = 8;
    localparam int ROW_W   = $clog2(ROWS);
    localparam int DWELL_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

endpackage

// File: rtl/frame_bank2.sv
// Two-bank row-pattern store: writes go to the back bank, reads come from the front bank.
module frame_bank2 #(
    parameter int ROWS = matrix_pkg::ROWS,
    parameter int COLS = matrix_pkg::COLS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_addr,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    toggle,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    output logic [COLS-1:0]         rd_data
);

    logic [COLS-1:0] mem [2][ROWS];
    logic            front;
    logic            rd_bank;

    always_ff @(posedge clk) begin
        if (reset) begin
            front <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    mem[b][r] <= '0;
                end
            end
        end else begin
            if (wr_en) begin
                mem[~front][wr_addr] <= wr_data;
            end
            if (toggle) begin
                front <= ~front;
            end
        end
    end

    // The read returns what the front bank will hold after this edge, so the
    // caller can register it: a toggle selects the other bank, and a write to
    // that same bank and row is forwarded.
    always_comb begin
        rd_bank = front ^ toggle;
        rd_data = mem[rd_bank][rd_row];
        if (wr_en && (rd_bank != front) && (wr_addr == rd_row)) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/matrix_scan_driver.sv
// Row-multiplexed scanner for a double-buffered 8x8 LED matrix with one blank cycle between rows.
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int ROWS    = matrix_pkg::ROWS,
    parameter int COLS    = matrix_pkg::COLS,
    parameter int DWELL_W = matrix_pkg::DWELL_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [DWELL_W-1:0]      dwell,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_addr,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    swap_req,
    output logic [COLS-1:0]         col_out,
    output logic [$clog2(ROWS)-1:0] row_idx,
    output logic                    row_en,
    output logic                    frame_tick,
    output logic                    swap_pending
);

    localparam int ROW_BITS = $clog2(ROWS);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

    scan_state_t         state, state_n;
    logic [ROW_BITS-1:0] row_n;
    logic [DWELL_W-1:0]  cnt, cnt_n;
    logic [DWELL_W-1:0]  dwell_eff;
    logic                wrap_edge;
    logic                toggle;
    logic [COLS-1:0]     rd_data;

    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    frame_bank2 #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .toggle  (toggle),
        .rd_row  (row_n),
        .rd_data (rd_data)
    );

    always_comb begin
        state_n   = state;
        row_n     = row_idx;
        cnt_n     = cnt;
        wrap_edge = 1'b0;
        toggle    = 1'b0;
        case (state)
            IDLE: begin
                row_n  = '0;
                toggle = swap_pending;
                if (enable) begin
                    state_n = SHOW;
                    cnt_n   = dwell_eff;
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_n = IDLE;
                    row_n   = '0;
                end else if (cnt <= DWELL_W'(1)) begin
                    // Row index moves on as the row blanks, giving the external
                    // decoder a dark cycle to settle before the next row lights.
                    state_n   = BLANK;
                    row_n     = row_idx + ROW_BITS'(1);
                    wrap_edge = (row_idx == LAST_ROW);
                    toggle    = wrap_edge && swap_pending;
                    cnt_n     = '0;
                end else begin
                    cnt_n = cnt - DWELL_W'(1);
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_n = IDLE;
                    row_n   = '0;
                end else begin
                    state_n = SHOW;
                    cnt_n   = dwell_eff;
                end
            end
            default: begin
                state_n = IDLE;
                row_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            row_idx      <= '0;
            cnt          <= '0;
            row_en       <= 1'b0;
            col_out      <= '0;
            frame_tick   <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            state        <= state_n;
            row_idx      <= row_n;
            cnt          <= cnt_n;
            row_en       <= (state_n == SHOW);
            col_out      <= (state_n == SHOW) ? rd_data : '0;
            frame_tick   <= wrap_edge;
            swap_pending <= swap_req | (swap_pending & ~toggle);
        end
    end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver; a behavioural model queues expected outputs per cycle.
module tb_matrix_scan_driver;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] dwell;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       swap_req;
    logic [7:0] col_out;
    logic [2:0] row_idx;
    logic       row_en;
    logic       frame_tick;
    logic       swap_pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] col;
        logic [2:0] row;
        logic       en;
        logic       tick;
        logic       pend;
    } exp_t;

    exp_t exp_q[$];

    // Model state: 0 = idle, 1 = showing, 2 = blanking.
    int         m_state;
    logic [2:0] m_row;
    int         m_left;
    bit         m_front;
    bit         m_pending;
    bit         m_tick;
    logic [7:0] m_bank [2][8];

    matrix_scan_driver dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .dwell        (dwell),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .swap_req     (swap_req),
        .col_out      (col_out),
        .row_idx      (row_idx),
        .row_en       (row_en),
        .frame_tick   (frame_tick),
        .swap_pending (swap_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic modelStep(input logic rst, input logic en, input logic [7:0] dw,
                             input logic we, input logic [2:0] wa, input logic [7:0] wd,
                             input logic sr);
        bit apply;
        bit old_front;
        int eff;
        eff = (dw == 8'd0) ? 1 : int'(dw);
        if (rst) begin
            m_state   = 0;
            m_row     = 3'd0;
            m_left    = 0;
            m_front   = 1'b0;
            m_pending = 1'b0;
            m_tick    = 1'b0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 8; r++)
                    m_bank[b][r] = 8'h00;
            return;
        end
        apply     = 1'b0;
        m_tick    = 1'b0;
        old_front = m_front;
        if (m_state == 0) begin
            apply = m_pending;
            m_row = 3'd0;
            if (en) begin
                m_state = 1;
                m_left  = eff;
            end
        end else if (!en) begin
            m_state = 0;
            m_row   = 3'd0;
        end else if (m_state == 1) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_state = 2;
                m_row   = m_row + 3'd1;
                if (m_row == 3'd0) begin
                    m_tick = 1'b1;
                    apply  = m_pending;
                end
            end
        end else begin
            m_state = 1;
            m_left  = eff;
        end
        if (we) m_bank[!old_front][wa] = wd;
        if (apply) begin
            m_front   = !m_front;
            m_pending = 1'b0;
        end
        if (sr) m_pending = 1'b1;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = exp_q.pop_front();
        checkValue("col_out", 32'(col_out), 32'(e.col));
        checkValue("row_idx", 32'(row_idx), 32'(e.row));
        checkValue("row_en", 32'(row_en), 32'(e.en));
        checkValue("frame_tick", 32'(frame_tick), 32'(e.tick));
        checkValue("swap_pending", 32'(swap_pending), 32'(e.pend));
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic [7:0] dw,
                                 input logic we, input logic [2:0] wa, input logic [7:0] wd,
                                 input logic sr);
        exp_t e;
        reset    = rst;
        enable   = en;
        dwell    = dw;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        swap_req = sr;
        modelStep(rst, en, dw, we, wa, wd, sr);
        e.en   = (m_state == 1);
        e.col  = (m_state == 1) ? m_bank[m_front][m_row] : 8'h00;
        e.row  = m_row;
        e.tick = m_tick;
        e.pend = m_pending;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic runIdle(input int n, input logic en, input logic [7:0] dw);
        repeat (n) applyStimulus(1'b0, en, dw, 1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    task automatic measurePeriod(input logic [7:0] dw, output int period);
        int guard;
        guard = 0;
        while (frame_tick !== 1'b1 && guard < 100) begin
            runIdle(1, 1'b1, dw);
            guard++;
        end
        period = 0;
        do begin
            runIdle(1, 1'b1, dw);
            period++;
        end while (frame_tick !== 1'b1 && period < 100);
    endtask

    initial begin
        int period;
        int guard;
        reset    = 1'b1;
        enable   = 1'b0;
        dwell    = 8'd3;
        wr_en    = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 8'h00;
        swap_req = 1'b0;

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 8'd3, 1'b0, 3'd0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd3, 1'b0, 3'd0, 8'h00, 1'b0);
        checkValue("reset_row_en", 32'(row_en), 32'd0);

        $display("[TB] blank scan, dwell 3");
        runIdle(40, 1'b1, 8'd3);
        measurePeriod(8'd3, period);
        checkValue("period_dwell3", 32'(period), 32'd32);

        $display("[TB] load back buffer, then swap");
        for (int r = 0; r < 8; r++)
            applyStimulus(1'b0, 1'b1, 8'd3, 1'b1, 3'(r), 8'(1 << r), 1'b0);
        runIdle(40, 1'b1, 8'd3);
        applyStimulus(1'b0, 1'b1, 8'd3, 1'b0, 3'd0, 8'h00, 1'b1);
        checkValue("pending_set", 32'(swap_pending), 32'd1);
        guard = 0;
        do begin
            runIdle(1, 1'b1, 8'd3);
            guard++;
        end while (frame_tick !== 1'b1 && guard < 100);
        checkValue("pending_drop_on_tick", 32'(swap_pending), 32'd0);
        guard = 0;
        while (!(row_idx === 3'd3 && row_en === 1'b1) && guard < 100) begin
            runIdle(1, 1'b1, 8'd3);
            guard++;
        end
        checkValue("row3_pattern", 32'(col_out), 32'h08);
        runIdle(34, 1'b1, 8'd3);

        $display("[TB] dwell 0");
        runIdle(20, 1'b1, 8'd0);
        measurePeriod(8'd0, period);
        checkValue("period_dwell0", 32'(period), 32'd16);

        $display("[TB] disable during row 5");
        guard = 0;
        while (!(row_idx === 3'd5 && row_en === 1'b1) && guard < 100) begin
            runIdle(1, 1'b1, 8'd3);
            guard++;
        end
        checkValue("row5_reached", 32'(row_idx), 32'd5);
        applyStimulus(1'b0, 1'b0, 8'd3, 1'b0, 3'd0, 8'h00, 1'b0);
        checkValue("disable_row_en", 32'(row_en), 32'd0);
        checkValue("disable_row_idx", 32'(row_idx), 32'd0);
        runIdle(3, 1'b0, 8'd3);
        runIdle(12, 1'b1, 8'd3);

        $display("[TB] swap and write on the swapping wrap");
        applyStimulus(1'b0, 1'b1, 8'd3, 1'b0, 3'd0, 8'h00, 1'b1);
        guard = 0;
        while (!(m_state == 1 && m_row == 3'd7 && m_left == 1) && guard < 100) begin
            runIdle(1, 1'b1, 8'd3);
            guard++;
        end
        applyStimulus(1'b0, 1'b1, 8'd3, 1'b1, 3'd2, 8'hAA, 1'b1);
        checkValue("wrap_tick", 32'(frame_tick), 32'd1);
        checkValue("pending_kept", 32'(swap_pending), 32'd1);
        guard = 0;
        while (!(row_idx === 3'd2 && row_en === 1'b1) && guard < 100) begin
            runIdle(1, 1'b1, 8'd3);
            guard++;
        end
        checkValue("new_front_row2", 32'(col_out), 32'hAA);
        guard = 0;
        do begin
            runIdle(1, 1'b1, 8'd3);
            guard++;
        end while (frame_tick !== 1'b1 && guard < 100);
        checkValue("second_swap_pending", 32'(swap_pending), 32'd0);
        runIdle(34, 1'b1, 8'd3);

        $display("[TB] reset mid-frame");
        runIdle(13, 1'b1, 8'd3);
        applyStimulus(1'b1, 1'b1, 8'd3, 1'b0, 3'd0, 8'h00, 1'b0);
        checkValue("midreset_col", 32'(col_out), 32'd0);
        checkValue("midreset_pending", 32'(swap_pending), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'd3, 1'b0, 3'd0, 8'h00, 1'b1);
        runIdle(70, 1'b1, 8'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
